act_skew_feeder: RTL and testbench
==================================

ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 Parameters SHALL be: ACC_W, default 16, lane data width; DEPTH, default 4, input FIFO entries (power of 2, >=2); KW, default 8, width of k_len.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-low reset (0 = reset).
REQ-005 in_valid  input  1  upstream vector valid.
REQ-006 in_ready  output  1  FIFO can accept a vector.
REQ-007 in_data_0/1/2  input  ACC_W each, signed  one 3-lane activation vector.
REQ-008 start  input  1  begin a tile; sampled only in IDLE.
REQ-009 k_len  input  KW  vectors per tile, latched on accepted start.
REQ-010 a_out_0/1/2  output  ACC_W each, signed  skewed lane data to the MAC row.
REQ-011 valid_out_0/1/2  output  1 each  per-lane valid to the MAC row.
REQ-012 clear_out  output  1  accumulator clear pulse.
REQ-013 busy  output  1  state != IDLE.
REQ-014 done  output  1  one-cycle tile-complete pulse.

Function
REQ-015 The FIFO SHALL push when in_valid && in_ready, in any state; in_ready = !full, so there is no push while full even if a pop occurs in the same cycle.
REQ-016 Simultaneous push and pop when not full or empty SHALL keep the occupancy constant; pointers SHALL wrap modulo DEPTH.
REQ-017 The FSM SHALL have states IDLE, CLEAR, STREAM and DRAIN.
- IDLE -> CLEAR on start (k_len latched).
- CLEAR lasts 1 cycle with clear_out=1, then goes to STREAM, or directly to DRAIN if k_len==0.
- STREAM -> DRAIN in the cycle after the pop that makes the pop count equal k_len.
- DRAIN lasts exactly 2 cycles, then goes to IDLE.
REQ-018 In STREAM, the block SHALL pop one vector per cycle when the FIFO is non-empty; an empty FIFO SHALL produce a bubble with no pop and no count advance.
REQ-019 A vector popped in cycle P SHALL appear as follows: lane 0 on a_out_0 with valid_out_0=1 in cycle P+1; lane 1 in P+2; lane 2 in P+3. These are all registered.
REQ-020 Each valid_out_n SHALL be 0 in any cycle with no corresponding popped vector, including bubbles, CLEAR, and cycles after the final skew.
REQ-021 done SHALL be 1 only in the first IDLE cycle after DRAIN; this coincides with the last valid_out_2.
REQ-022 start asserted while busy SHALL be ignored.
REQ-023 clear_out SHALL never be asserted in the same cycle as any valid_out_n.
REQ-024 FIFO contents not consumed by a tile SHALL be retained for the next tile.

Reset
REQ-025 While rst==0 at a clock edge, the following SHALL be set: state=IDLE, FIFO empty, pop count 0, latched k_len 0, all valid_out_n=0, clear_out=0, done=0, a_out_n=0, skew registers 0.
REQ-026 Reset mid-tile SHALL discard FIFO contents and in-flight skewed data; no valid_out or done SHALL be produced for the aborted tile.
REQ-027 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-028 Macro FEEDER_ZERO_PAD_EN SHALL control lane data while invalid.
- Defined: each a_out_n SHALL be driven to 0 whenever valid_out_n==0.
- Not defined: each a_out_n SHALL hold its last valid value while valid_out_n==0.
- Handshake, valid, clear and done timing SHALL be identical in both builds.

Verification
REQ-029 Basic tile: preload vectors (1,2,3),(4,5,6) then start with k_len=2. Required response:
- clear_out in the cycle after start.
- a_out_0 = 1,4 in consecutive cycles.
- a_out_1 = 2,5 one cycle later.
- a_out_2 = 3,6 two cycles later.
- done with the 6.
REQ-030 Bubble: start with k_len=3 and the FIFO empty; push (7,8,9), skip one cycle, then push (1,1,1) and (2,2,2). Required response: the valid_out_0 pattern shows a one-cycle gap, the same gap appears skewed on lanes 1 and 2, and done occurs after 3 pops.
REQ-031 Full FIFO with DEPTH=4: push 4 vectors in IDLE. Required response: in_ready=0; a 5th in_valid is not accepted; after start, in_ready returns to 1 one cycle after the first pop.
REQ-032 k_len=0: start. Required response: clear_out pulse, no valid_out_n asserted, done exactly 4 cycles after start is sampled, and FIFO occupancy unchanged.
REQ-033 Reset mid-tile: set rst=0 for 1 cycle during STREAM with 2 vectors in flight. Required response: all valids 0, busy=0, in_ready=1, no done; the next tile runs normally.
REQ-034 Build configuration: run REQ-029 once with FEEDER_ZERO_PAD_EN defined and once without it. Required response:
- Defined: a_out_0=0 after the 4.
- Not defined: a_out_0 holds 4.

Source files
------------

// File: rtl/act_skew_feeder_if.sv
// Activation input stream interface for act_skew_feeder.
// Carries one 3-lane signed activation vector per accepted transfer.
//   in_valid            upstream vector valid (master -> slave)
//   in_ready            feeder FIFO can accept a vector (slave -> master)
//   in_data_0/1/2       lane data, ACC_W bits each, signed (master -> slave)
interface act_skew_feeder_if #(
  parameter int ACC_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [ACC_W-1:0] in_data_0;
  logic signed [ACC_W-1:0] in_data_1;
  logic signed [ACC_W-1:0] in_data_2;

  modport master (
    output in_valid,
    output in_data_0,
    output in_data_1,
    output in_data_2,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data_0,
    input  in_data_1,
    input  in_data_2,
    output in_ready
  );
endinterface

// File: rtl/act_skew_feeder.sv
// Activation skew feeder: buffers 3-lane activation vectors in a small FIFO and,
// per tile of k_len vectors, streams them to a MAC row with a diagonal skew
// (lane n delayed by n extra cycles). Each tile starts with a one-cycle
// accumulator clear and ends with a one-cycle done pulse.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-low reset
//   in_if               input vector stream (slave side of act_skew_feeder_if)
//   start, k_len        begin a tile of k_len vectors (sampled only when idle)
//   a_out_0/1/2         skewed lane data to the MAC row
//   valid_out_0/1/2     per-lane valid to the MAC row
//   clear_out           accumulator clear pulse
//   busy                tile in progress
//   done                one-cycle tile-complete pulse
//
// Build option: define FEEDER_ZERO_PAD_EN to force a_out_n to zero whenever
// valid_out_n is low; otherwise a_out_n holds its last valid value.
module act_skew_feeder #(
  parameter int ACC_W = 16,
  parameter int DEPTH = 4,
  parameter int KW    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  act_skew_feeder_if.slave        in_if,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  output logic signed [ACC_W-1:0] a_out_0,
  output logic signed [ACC_W-1:0] a_out_1,
  output logic signed [ACC_W-1:0] a_out_2,
  output logic                    valid_out_0,
  output logic                    valid_out_1,
  output logic                    valid_out_2,
  output logic                    clear_out,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StClear, StStream, StDrain} state_e;

  state_e                  state_q;
  logic [KW-1:0]           k_len_q;
  logic [KW-1:0]           pop_cnt_q;
  logic                    drain_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]             wr_ptr_q;
  logic [AW:0]             rd_ptr_q;
  logic signed [ACC_W-1:0] mem0_q [DEPTH];
  logic signed [ACC_W-1:0] mem1_q [DEPTH];
  logic signed [ACC_W-1:0] mem2_q [DEPTH];

  // Skew stages: lane 1 needs one extra register, lane 2 needs two.
  logic                    pv1_q;
  logic                    pv2_q;
  logic signed [ACC_W-1:0] sk1_q;
  logic signed [ACC_W-1:0] sk2a_q;
  logic signed [ACC_W-1:0] sk2b_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    push  = in_if.in_valid && !full;
    // pop_cnt_q < k_len_q always holds in StStream, so no count check is needed.
    pop   = (state_q == StStream) && !empty;
  end

  assign in_if.in_ready = !full;
  assign busy           = (state_q != StIdle);

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem0_q[wr_ptr_q[AW-1:0]] <= in_if.in_data_0;
      mem1_q[wr_ptr_q[AW-1:0]] <= in_if.in_data_1;
      mem2_q[wr_ptr_q[AW-1:0]] <= in_if.in_data_2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      k_len_q     <= '0;
      pop_cnt_q   <= '0;
      drain_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pv1_q       <= 1'b0;
      pv2_q       <= 1'b0;
      sk1_q       <= '0;
      sk2a_q      <= '0;
      sk2b_q      <= '0;
      a_out_0     <= '0;
      a_out_1     <= '0;
      a_out_2     <= '0;
      valid_out_0 <= 1'b0;
      valid_out_1 <= 1'b0;
      valid_out_2 <= 1'b0;
      clear_out   <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      clear_out <= (state_q == StIdle) && start;
      done      <= (state_q == StDrain) && drain_q;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            k_len_q   <= k_len;
            pop_cnt_q <= '0;
            state_q   <= StClear;
          end
        end
        StClear: begin
          drain_q <= 1'b0;
          state_q <= (k_len_q == '0) ? StDrain : StStream;
        end
        StStream: begin
          if (pop) begin
            pop_cnt_q <= pop_cnt_q + 1'b1;
            if (pop_cnt_q + KW'(1) == k_len_q) begin
              drain_q <= 1'b0;
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          drain_q <= 1'b1;
          if (drain_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Skew pipeline: lane n of a vector popped in cycle P appears in P+1+n.
      pv1_q       <= pop;
      pv2_q       <= pv1_q;
      valid_out_0 <= pop;
      valid_out_1 <= pv1_q;
      valid_out_2 <= pv2_q;
      if (pop) begin
        sk1_q  <= mem1_q[rd_ptr_q[AW-1:0]];
        sk2a_q <= mem2_q[rd_ptr_q[AW-1:0]];
      end
      if (pv1_q) sk2b_q <= sk2a_q;

`ifdef FEEDER_ZERO_PAD_EN
      a_out_0 <= pop   ? mem0_q[rd_ptr_q[AW-1:0]] : '0;
      a_out_1 <= pv1_q ? sk1_q : '0;
      a_out_2 <= pv2_q ? sk2b_q : '0;
`else
      if (pop)   a_out_0 <= mem0_q[rd_ptr_q[AW-1:0]];
      if (pv1_q) a_out_1 <= sk1_q;
      if (pv2_q) a_out_2 <= sk2b_q;
`endif
    end
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Self-checking bench for act_skew_feeder: directed tiles (basic, bubble, full
// FIFO, zero-length, mid-tile reset) followed by randomized traffic, all checked
// against a cycle-indexed reference model of the tile rules.
module tb_act_skew_feeder;
  localparam int ACC_W   = 16;
  localparam int DEPTH   = 4;
  localparam int KW      = 8;
  localparam int MaxEdge = 6000;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [KW-1:0]           k_len;
  logic signed [ACC_W-1:0] a_out_0, a_out_1, a_out_2;
  logic                    valid_out_0, valid_out_1, valid_out_2;
  logic                    clear_out, busy, done;

  always #5 clk = ~clk;

  act_skew_feeder_if #(.ACC_W(ACC_W)) in_if ();

  act_skew_feeder #(.ACC_W(ACC_W), .DEPTH(DEPTH), .KW(KW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_if       (in_if.slave),
    .start       (start),
    .k_len       (k_len),
    .a_out_0     (a_out_0),
    .a_out_1     (a_out_1),
    .a_out_2     (a_out_2),
    .valid_out_0 (valid_out_0),
    .valid_out_1 (valid_out_1),
    .valid_out_2 (valid_out_2),
    .clear_out   (clear_out),
    .busy        (busy),
    .done        (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, tile progress as a phase number, and lane
  // outputs scheduled by edge number (lane n of a pop at edge k is due at k+n).
  logic [3*ACC_W-1:0] fq[$];
  int                 phase;   // 0 idle, 1 clear, 2 stream, 3/4 drain
  int                 klen_m;
  int                 pops_m;
  int                 edge_n = 0;
  bit                 sv [3][MaxEdge];
  logic [ACC_W-1:0]   sa [3][MaxEdge];
  logic [ACC_W-1:0]   last_a [3];
  bit                 e_clear, e_done, e_busy, e_ready;

  task automatic step(input bit r, input bit v, input logic [ACC_W-1:0] d0,
                      input logic [ACC_W-1:0] d1, input logic [ACC_W-1:0] d2,
                      input bit s, input int kl);
    logic [3*ACC_W-1:0] w;
    bit                 was_full;
    logic [ACC_W-1:0]   dut_a [3];
    bit                 dut_v [3];
    logic [ACC_W-1:0]   exp_a;
    int                 k;
    k = edge_n;
    if (k + 4 >= MaxEdge) begin
      $display("FAIL edge_budget: got %0d expected below %0d", k, MaxEdge - 4);
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "edge budget exceeded");
    end
    rst             = r;
    in_if.in_valid  = v;
    in_if.in_data_0 = d0;
    in_if.in_data_1 = d1;
    in_if.in_data_2 = d2;
    start           = s;
    k_len           = KW'(kl);
    @(posedge clk);
    if (!r) begin
      fq.delete();
      phase  = 0;
      klen_m = 0;
      pops_m = 0;
      for (int n = 0; n < 3; n++) begin
        for (int j = k; j < k + 4; j++) sv[n][j] = 1'b0;
        last_a[n] = '0;
      end
      e_clear = 1'b0;
      e_done  = 1'b0;
    end else begin
      was_full = (fq.size() == DEPTH);
      e_clear  = (phase == 0) && s;
      e_done   = (phase == 4);
      case (phase)
        0: if (s) begin klen_m = kl; pops_m = 0; phase = 1; end
        1: phase = (klen_m == 0) ? 3 : 2;
        2: begin
          if (fq.size() > 0) begin
            w = fq.pop_front();
            for (int n = 0; n < 3; n++) begin
              sv[n][k+n] = 1'b1;
              sa[n][k+n] = w[n*ACC_W +: ACC_W];
            end
            pops_m++;
            if (pops_m == klen_m) phase = 3;
          end
        end
        3: phase = 4;
        default: phase = 0;
      endcase
      if (v && !was_full) fq.push_back({d2, d1, d0});
    end
    e_busy  = (phase != 0);
    e_ready = (fq.size() < DEPTH);

    @(negedge clk);
    dut_a[0] = a_out_0; dut_a[1] = a_out_1; dut_a[2] = a_out_2;
    dut_v[0] = valid_out_0; dut_v[1] = valid_out_1; dut_v[2] = valid_out_2;
    for (int n = 0; n < 3; n++) begin
      if (sv[n][k]) last_a[n] = sa[n][k];
`ifdef FEEDER_ZERO_PAD_EN
      exp_a = sv[n][k] ? sa[n][k] : '0;
`else
      exp_a = last_a[n];
`endif
      check_eq($sformatf("valid_out_%0d", n), {31'b0, dut_v[n]}, {31'b0, sv[n][k]});
      check_eq($sformatf("a_out_%0d", n), {{(32-ACC_W){1'b0}}, dut_a[n]},
               {{(32-ACC_W){1'b0}}, exp_a});
    end
    check_eq("clear_out", {31'b0, clear_out}, {31'b0, e_clear});
    check_eq("done", {31'b0, done}, {31'b0, e_done});
    check_eq("busy", {31'b0, busy}, {31'b0, e_busy});
    check_eq("in_ready", {31'b0, in_if.in_ready}, {31'b0, e_ready});
    edge_n++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, '0, '0, '0, 1'b0, 0);
  endtask

  task automatic push(input logic [ACC_W-1:0] d0, input logic [ACC_W-1:0] d1,
                      input logic [ACC_W-1:0] d2);
    step(1'b1, 1'b1, d0, d1, d2, 1'b0, 0);
  endtask

  task automatic start_tile(input int kl);
    step(1'b1, 1'b0, '0, '0, '0, 1'b1, kl);
  endtask

  initial begin
    phase  = 0;
    klen_m = 0;
    pops_m = 0;
    for (int n = 0; n < 3; n++) last_a[n] = '0;

    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 0);
    step(1'b0, 1'b1, 16'h55, 16'h66, 16'h77, 1'b1, 3);
    idle(1);

    // Basic tile
    push(16'd1, 16'd2, 16'd3);
    push(16'd4, 16'd5, 16'd6);
    start_tile(2);
    idle(8);

    // Bubble: empty FIFO at start, gap between first and second vector
    start_tile(3);
    idle(1);
    push(16'd7, 16'd8, 16'd9);
    idle(1);
    push(16'd1, 16'd1, 16'd1);
    push(16'd2, 16'd2, 16'd2);
    idle(8);

    // Full FIFO, 5th push rejected; partial tile leaves 2 entries behind
    for (int i = 0; i < 5; i++) push(16'(10 + i), 16'(20 + i), 16'(16'hFFF0 + i));
    start_tile(2);
    step(1'b1, 1'b0, '0, '0, '0, 1'b1, 5);  // start while busy is ignored
    idle(8);
    start_tile(0);
    idle(6);
    start_tile(2);
    idle(8);

    // Reset mid-tile with vectors in flight
    push(16'd31, 16'd32, 16'd33);
    push(16'd34, 16'd35, 16'd36);
    push(16'd37, 16'd38, 16'd39);
    start_tile(3);
    idle(3);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 0);
    idle(6);
    push(16'd1, 16'd2, 16'd3);
    push(16'd4, 16'd5, 16'd6);
    start_tile(2);
    idle(8);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) != 0),
           16'($urandom), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, 6)));
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
